sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering byte/word streams between blocks in the same clock domain (e.g. register-file to UART TX path). It is the next generation of the team's FIFO storage: it owns pointers, occupancy count, full/empty and programmable almost-full/almost-empty flags. Optional sticky overflow/underflow error reporting can be compiled in.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_dpram.sv | 42 ++++
 rtl/sync_fifo.sv | 131 +++++++++++++
 tb/tb_sync_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg
// Shared constants, pointer-width helper and status-flag grouping for the
// single-clock FIFO family.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy-derived status flags, all decoded from the registered count.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

`default_nettype wire

// File: rtl/fifo_dpram.sv
// ============================================================================
// fifo_dpram
// FIFO storage: synchronous write port, asynchronous read port, and an
// asynchronous active-low clear of every entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_dpram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the write word; reset wipes every entry so stale reads return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Show-ahead read straight from storage.
  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo
// Single-clock first-word-fall-through FIFO with occupancy count, full/empty
// and programmable almost-full/almost-empty flags.
// Optional feature macro: SYNC_FIFO_ERR_EN adds sticky OVF/UDF flags and
// the ERR_CLR input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       W_DATA,
  input  logic                   W_INC,
  input  logic                   R_INC,
  output logic [WIDTH-1:0]       R_DATA,
  output logic                   W_FULL,
  output logic                   R_EMPTY,
  output logic                   ALMOST_FULL,
  output logic                   ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0] COUNT
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                   ERR_CLR,
  output logic                   OVF,
  output logic                   UDF
`endif
);

  localparam int ADDRESS = $clog2(DEPTH);
  localparam int PTR_W   = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_CNT   = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT   = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  fifo_status_t     status;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still takes a read
  // and an empty FIFO still takes a write in the same cycle.
  assign wr_acc = W_INC && !status.full;
  assign rd_acc = R_INC && !status.empty;

  // Decode all status flags from the registered occupancy.
  always_comb begin
    status              = '0;
    status.full         = (count == FULL_CNT);
    status.empty        = (count == '0);
    status.almost_full  = (count >= AF_CNT);
    status.almost_empty = (count <= AE_CNT);
  end

  // Advance pointers on accepted requests; the MSB toggles on wrap.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
    end
  end

  // Track occupancy: only one-sided accepts change the count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_dpram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDRESS)
  ) u_mem (
    .clk   (CLK),
    .rst_n (RST),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDRESS-1:0]),
    .wdata (W_DATA),
    .raddr (rd_ptr[ADDRESS-1:0]),
    .rdata (R_DATA)
  );

  assign W_FULL       = status.full;
  assign R_EMPTY      = status.empty;
  assign ALMOST_FULL  = status.almost_full;
  assign ALMOST_EMPTY = status.almost_empty;
  assign COUNT        = count;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf;
  logic udf;

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (W_INC && status.full)  || (ovf && !ERR_CLR);
      udf <= (R_INC && status.empty) || (udf && !ERR_CLR);
    end
  end

  assign OVF = ovf;
  assign UDF = udf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// tb_sync_fifo
// Directed bench for sync_fifo (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2) with a
// queue-based reference model checked every cycle, plus literal checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] w_data;
  logic             w_inc;
  logic             r_inc;
  logic             err_clr;
  logic [WIDTH-1:0] r_data;
  logic             w_full;
  logic             r_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [3:0]       count;
  logic             ovf;
  logic             udf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  bit               m_ovf;
  bit               m_udf;

  sync_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AFL),
    .AE_LEVEL (AEL)
  ) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .W_DATA       (w_data),
    .W_INC        (w_inc),
    .R_INC        (r_inc),
    .R_DATA       (r_data),
    .W_FULL       (w_full),
    .R_EMPTY      (r_empty),
    .ALMOST_FULL  (almost_full),
    .ALMOST_EMPTY (almost_empty),
    .COUNT        (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .ERR_CLR      (err_clr),
    .OVF          (ovf),
    .UDF          (udf)
`endif
  );

`ifndef SYNC_FIFO_ERR_EN
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated with the pre-edge occupancy.
  always @(posedge clk) begin
    int  n;
    bit  wa;
    bit  ra;
    if (rst_n) begin
      n  = q.size();
      wa = w_inc && (n != DEPTH);
      ra = r_inc && (n != 0);
      m_ovf = (w_inc && n == DEPTH) || (m_ovf && !err_clr);
      m_udf = (r_inc && n == 0) || (m_udf && !err_clr);
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(w_data);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_count", 32'(count), 32'(q.size()));
      check("m_full", 32'(w_full), 32'(q.size() == DEPTH));
      check("m_empty", 32'(r_empty), 32'(q.size() == 0));
      check("m_afull", 32'(almost_full), 32'(q.size() >= AFL));
      check("m_aempty", 32'(almost_empty), 32'(q.size() <= AEL));
      if (q.size() != 0) check("m_rdata", 32'(r_data), 32'(q[0]));
`ifdef SYNC_FIFO_ERR_EN
      check("m_ovf", 32'(ovf), 32'(m_ovf));
      check("m_udf", 32'(udf), 32'(m_udf));
`endif
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit clr);
    w_inc   = w;
    r_inc   = r;
    w_data  = d;
    err_clr = clr;
    @(posedge clk);
    #1;
    w_inc   = 1'b0;
    r_inc   = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    rst_n   = 1'b0;
    w_inc   = 1'b0;
    r_inc   = 1'b0;
    w_data  = '0;
    err_clr = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(r_empty), 1);
    check("rst_full", 32'(w_full), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_rdata", 32'(r_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill 0x01..0x08, pinning almost-flag thresholds on the way up.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 2) check("fill_ae_at2", 32'(almost_empty), 1);
      if (i == 3) check("fill_ae_at3", 32'(almost_empty), 0);
      if (i == 5) check("fill_af_at5", 32'(almost_full), 0);
      if (i == 6) check("fill_af_at6", 32'(almost_full), 1);
    end
    check("fill_count", 32'(count), 8);
    check("fill_full", 32'(w_full), 1);

    // Drain in order, pinning thresholds on the way down.
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", 32'(r_data), 32'(i));
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      if (i == 2) check("drain_af_at6", 32'(almost_full), 1);
      if (i == 3) check("drain_af_at5", 32'(almost_full), 0);
      if (i == 5) check("drain_ae_at3", 32'(almost_empty), 0);
      if (i == 6) check("drain_ae_at2", 32'(almost_empty), 1);
    end
    check("drain_empty", 32'(r_empty), 1);

    // Wrap: three rounds of 5 writes then 5 reads.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'(8'h10 + rnd * 5 + k), 1'b0);
      for (int k = 0; k < 5; k++) begin
        check("wrap_data", 32'(r_data), 32'(8'h10 + rnd * 5 + k));
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
      end
      check("wrap_count", 32'(count), 0);
    end

    // Empty with both requests: only the write lands.
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    check("eboth_count", 32'(count), 1);
    check("eboth_rdata", 32'(r_data), 32'hA5);
    check("eboth_empty", 32'(r_empty), 0);

    // Mid-level with both requests: count holds at 4.
    cycle(1'b1, 1'b0, 8'hB0, 1'b0);
    cycle(1'b1, 1'b0, 8'hB1, 1'b0);
    cycle(1'b1, 1'b0, 8'hB2, 1'b0);
    check("mid_count_pre", 32'(count), 4);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    check("mid_count", 32'(count), 4);
    check("mid_rdata", 32'(r_data), 32'hB0);

    // Full with both requests: read wins, new word dropped.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 8'(8'hC0 + k), 1'b0);
    check("fboth_full_pre", 32'(w_full), 1);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    check("fboth_count", 32'(count), 7);
    check("fboth_rdata", 32'(r_data), 32'hB1);
    for (int k = 0; k < 7; k++) begin
      if (k == 6) check("fboth_last", 32'(r_data), 32'hC3);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("fboth_empty", 32'(r_empty), 1);

    // Reset mid-operation at count 5, pulsed between edges.
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'(8'hD0 + k), 1'b0);
    check("mrst_count_pre", 32'(count), 5);
    #1;
    rst_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check("mrst_count", 32'(count), 0);
    check("mrst_empty", 32'(r_empty), 1);
    check("mrst_rdata", 32'(r_data), 0);
    check("mrst_full", 32'(w_full), 0);
    check("mrst_aempty", 32'(almost_empty), 1);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h5A, 1'b0);
    check("post_rst_rdata", 32'(r_data), 32'h5A);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("post_rst_stale", 32'(r_data), 0);

`ifdef SYNC_FIFO_ERR_EN
    // Underflow, overflow, and clear-versus-set priority.
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("udf_set", 32'(udf), 1);
    check("udf_ovf0", 32'(ovf), 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("udf_hold", 32'(udf), 1);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 8'(8'hE0 + k), 1'b0);
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_count", 32'(count), 8);
    cycle(1'b1, 1'b0, 8'hFF, 1'b1);
    check("clr_ovf_wins", 32'(ovf), 1);
    check("clr_udf", 32'(udf), 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_ovf", 32'(ovf), 0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
`endif

    d = r_data;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_stable", 32'(r_data), 32'(d));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
